// File: rtl/glyph_blitter.sv
// glyph_blitter: single-sprite, per-scanline glyph blitter.
// During horizontal blanking it fetches one 32-pixel glyph row from the glyph
// ROM (256 x 32, 1-cycle read latency) into a row buffer. During active video
// it turns that buffer into a per-pixel mask. Sprite position and glyph are
// latched on frame_start so that mid-frame updates cannot tear the image.
//
// Ports:
//   clk, reset               pixel clock, synchronous active-high reset
//   frame_start              latches spr_x/spr_y/spr_glyph/spr_en
//   line_start, line_y       start of hblank fetch for the upcoming line
//   px_valid, px_x           active-video pixel strobe and its column
//   spr_*                    sprite position, glyph index and enable
//   rom_ad/ce/oce/reset      glyph ROM control; rom_dout is the ROM data
//                            (bit 31 = leftmost pixel)
//   pix_valid, pix_on        px_valid delayed 1 cycle and the sprite mask
//   fetch_busy               high while a row fetch is in flight
module glyph_blitter #(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned ROW_LOG2   = 4,
    parameter int unsigned GLYPH_LOG2 = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           line_start,
    input  logic [Y_W-1:0]                 line_y,
    input  logic                           px_valid,
    input  logic [X_W-1:0]                 px_x,
    input  logic [X_W-1:0]                 spr_x,
    input  logic [Y_W-1:0]                 spr_y,
    input  logic [GLYPH_LOG2-1:0]          spr_glyph,
    input  logic                           spr_en,
    output logic [ROW_LOG2+GLYPH_LOG2-1:0] rom_ad,
    output logic                           rom_ce,
    output logic                           rom_oce,
    output logic                           rom_reset,
    input  logic [31:0]                    rom_dout,
    output logic                           pix_valid,
    output logic                           pix_on,
    output logic                           fetch_busy
);

    localparam int unsigned AW = ROW_LOG2 + GLYPH_LOG2;

    typedef enum logic [1:0] {StIdle, StFetch, StCapture} state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           rom_ad_q, rom_ad_d;
    logic [31:0]             row_buf_q, row_buf_d;
    logic [X_W-1:0]          spr_x_q, spr_x_d;
    logic [Y_W-1:0]          spr_y_q, spr_y_d;
    logic [GLYPH_LOG2-1:0]   glyph_q, glyph_d;
    logic                    en_q, en_d;
    logic                    pix_valid_q, pix_valid_d;
    logic                    pix_on_q, pix_on_d;

    // One extra bit on both differences: the MSB flags "coordinate is left of /
    // above the sprite" so that edge sprites clip instead of wrapping.
    logic [Y_W:0]            dy;
    logic                    in_sprite;
    logic [X_W:0]            col;
    logic [4:0]              bit_idx;

    always_comb begin
        dy        = {1'b0, line_y} - {1'b0, spr_y_q};
        in_sprite = en_q & ~dy[Y_W] & (dy < (Y_W+1)'(1 << ROW_LOG2));
        col       = {1'b0, px_x} - {1'b0, spr_x_q};
        bit_idx   = 5'd31 - col[4:0];
    end

    always_comb begin
        state_d     = state_q;
        rom_ad_d    = rom_ad_q;
        row_buf_d   = row_buf_q;
        spr_x_d     = spr_x_q;
        spr_y_d     = spr_y_q;
        glyph_d     = glyph_q;
        en_d        = en_q;

        if (frame_start) begin
            spr_x_d = spr_x;
            spr_y_d = spr_y;
            glyph_d = spr_glyph;
            en_d    = spr_en;
        end

        unique case (state_q)
            StFetch:   state_d = StCapture;
            StCapture: begin
                row_buf_d = rom_dout;
                state_d   = StIdle;
            end
            default:   state_d = StIdle;
        endcase

        // A new line_start always wins and restarts the fetch, abandoning any
        // capture in progress.
        if (line_start) begin
            if (in_sprite) begin
                state_d   = StFetch;
                rom_ad_d  = {glyph_q, dy[ROW_LOG2-1:0]};
                row_buf_d = row_buf_q;
            end else begin
                state_d   = StIdle;
                row_buf_d = '0;
            end
        end

        pix_valid_d = px_valid;
        pix_on_d    = px_valid & ~col[X_W] & (col < (X_W+1)'(32)) & row_buf_q[bit_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rom_ad_q    <= '0;
            row_buf_q   <= '0;
            spr_x_q     <= '0;
            spr_y_q     <= '0;
            glyph_q     <= '0;
            en_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_ad_q    <= rom_ad_d;
            row_buf_q   <= row_buf_d;
            spr_x_q     <= spr_x_d;
            spr_y_q     <= spr_y_d;
            glyph_q     <= glyph_d;
            en_q        <= en_d;
            pix_valid_q <= pix_valid_d;
            pix_on_q    <= pix_on_d;
        end
    end

    always_comb begin
        rom_ad     = rom_ad_q;
        rom_ce     = (state_q == StFetch);
        rom_oce    = 1'b1;
        rom_reset  = reset;
        pix_valid  = pix_valid_q;
        pix_on     = pix_on_q;
        fetch_busy = (state_q != StIdle);
    end

endmodule

// File: tb/tb_glyph_blitter.sv
// Self-checking bench for glyph_blitter: directed edge cases plus randomized
// sprites, checked against a pixel-level model of the blitter behaviour.
module tb_glyph_blitter;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        line_start;
    logic [9:0]  line_y;
    logic        px_valid;
    logic [9:0]  px_x;
    logic [9:0]  spr_x;
    logic [9:0]  spr_y;
    logic [3:0]  spr_glyph;
    logic        spr_en;
    logic [7:0]  rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [31:0] rom_dout;
    logic        pix_valid;
    logic        pix_on;
    logic        fetch_busy;

    glyph_blitter dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .line_start  (line_start),
        .line_y      (line_y),
        .px_valid    (px_valid),
        .px_x        (px_x),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_glyph   (spr_glyph),
        .spr_en      (spr_en),
        .rom_ad      (rom_ad),
        .rom_ce      (rom_ce),
        .rom_oce     (rom_oce),
        .rom_reset   (rom_reset),
        .rom_dout    (rom_dout),
        .pix_valid   (pix_valid),
        .pix_on      (pix_on),
        .fetch_busy  (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM: 1-cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) if (rom_ce === 1'b1) rom_dout <= mem[rom_ad];

    int ce_count;
    always @(posedge clk) if (rom_ce === 1'b1) ce_count++;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: latched sprite and the row the blitter should hold.
    int          m_sx, m_sy, m_g;
    bit          m_en;
    logic [31:0] exp_row;

    function automatic bit exp_pix(int x);
        int c;
        c = x - m_sx;
        if (c < 0 || c >= 32) return 1'b0;
        return exp_row[31-c];
    endfunction

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_g = 0; m_en = 1'b0; exp_row = '0;
    endtask

    task automatic do_frame(input int sx, input int sy, input int g, input bit en);
        @(negedge clk);
        frame_start = 1'b1;
        spr_x = 10'(sx); spr_y = 10'(sy); spr_glyph = 4'(g); spr_en = en;
        @(negedge clk);
        frame_start = 1'b0;
        m_sx = sx; m_sy = sy; m_g = g; m_en = en;
    endtask

    task automatic do_line(input int ly);
        int dy;
        bit ins;
        logic [7:0] a8;
        dy  = ly - m_sy;
        ins = m_en && dy >= 0 && dy < 16;
        a8  = 8'(m_g * 16 + dy);
        @(negedge clk);
        line_start = 1'b1; line_y = 10'(ly);
        @(negedge clk);
        line_start = 1'b0;
        check_eq("rom_ce_fetch", rom_ce, ins);
        check_eq("fetch_busy_fetch", fetch_busy, ins);
        if (ins) check_eq("rom_ad", rom_ad, a8);
        @(negedge clk);
        check_eq("rom_ce_capture", rom_ce, 0);
        @(negedge clk);
        check_eq("fetch_busy_done", fetch_busy, 0);
        exp_row = ins ? mem[a8] : 32'h0;
    endtask

    task automatic scan(input int lo, input int hi);
        bit pend;
        bit pe;
        pend = 1'b0;
        pe   = 1'b0;
        for (int x = lo; x <= hi; x++) begin
            @(negedge clk);
            if (pend) check_eq("pix_on", pix_on, pe);
            px_valid = 1'b1; px_x = 10'(x);
            pend = 1'b1; pe = exp_pix(x);
        end
        @(negedge clk);
        check_eq("pix_on", pix_on, pe);
        check_eq("pix_valid_hi", pix_valid, 1);
        px_valid = 1'b0;
        @(negedge clk);
        check_eq("pix_valid_lo", pix_valid, 0);
        check_eq("pix_on_idle", pix_on, 0);
    endtask

    initial begin
        int ce0;
        int sx, sy, g, ly;
        bit en;

        n_checks = 0; n_errors = 0; ce_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h23] = 32'h8000_0001;
        mem[8'h30] = 32'hFFFF_FFFF;
        rom_dout = '0;
        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; line_y = '0;
        px_valid = 1'b1; px_x = 10'd5;
        spr_x = 10'd3; spr_y = 10'd3; spr_glyph = 4'd1; spr_en = 1'b1;
        model_reset();

        // Reset held 4 cycles with busy inputs around it.
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rst_pix_valid", pix_valid, 0);
            check_eq("rst_pix_on", pix_on, 0);
            check_eq("rst_rom_ce", rom_ce, 0);
            check_eq("rst_rom_ad", rom_ad, 0);
            check_eq("rst_fetch_busy", fetch_busy, 0);
            check_eq("rst_rom_reset", rom_reset, 1);
        end
        reset = 1'b0; px_valid = 1'b0;
        @(negedge clk);
        check_eq("rom_oce", rom_oce, 1);
        check_eq("rom_reset_low", rom_reset, 0);
        scan(0, 639);
        check_eq("ce_after_reset", ce_count, 0);

        // Glyph 2 at (100,50), line 53 -> address 0x23, pixels 100 and 131.
        do_frame(100, 50, 2, 1'b1);
        do_line(53);
        scan(0, 639);

        // Lines just outside the sprite: no ROM access, no pixels.
        ce0 = ce_count;
        do_line(49);
        scan(0, 639);
        do_line(66);
        scan(0, 639);
        check_eq("ce_outside", ce_count, ce0);

        // Right-edge clipping with a full row.
        do_frame(620, 50, 3, 1'b1);
        do_line(50);
        scan(0, 639);

        // Mid-frame position change is ignored until frame_start.
        do_frame(100, 50, 2, 1'b1);
        @(negedge clk);
        spr_x = 10'd200;
        do_line(53);
        scan(90, 240);
        do_frame(200, 50, 2, 1'b1);
        do_line(53);
        scan(90, 240);

        // line_start during CAPTURE restarts with the new address.
        ce0 = ce_count;
        @(negedge clk);
        line_start = 1'b1; line_y = 10'd53;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        check_eq("capture_busy", fetch_busy, 1);
        check_eq("capture_ce", rom_ce, 0);
        line_start = 1'b1; line_y = 10'd54;
        @(negedge clk);
        line_start = 1'b0;
        check_eq("refetch_ce", rom_ce, 1);
        check_eq("refetch_ad", rom_ad, 8'h24);
        @(negedge clk);
        @(negedge clk);
        check_eq("refetch_count", ce_count, ce0 + 2);
        exp_row = mem[8'h24];
        scan(190, 240);

        // Reset during FETCH.
        do_frame(100, 50, 2, 1'b1);
        do_line(53);
        @(negedge clk);
        line_start = 1'b1; line_y = 10'd53;
        @(negedge clk);
        line_start = 1'b0;
        check_eq("pre_reset_busy", fetch_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_eq("post_reset_busy", fetch_busy, 0);
        check_eq("post_reset_ce", rom_ce, 0);
        scan(0, 639);

        // Randomized sprites and lines.
        for (int it = 0; it < 14; it++) begin
            sx = $urandom_range(0, 639);
            sy = $urandom_range(0, 479);
            g  = $urandom_range(0, 15);
            en = ($urandom_range(0, 3) != 0);
            do_frame(sx, sy, g, en);
            ly = sy + $urandom_range(0, 21) - 3;
            if (ly < 0) ly = 0;
            do_line(ly);
            scan(0, 639);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
